// File: rtl/dsc_roberts_window_feeder.sv
// Raster-scan front end for the serial DSC Roberts-cross core: buffers one row, forms 2x2 windows, runs the core, returns results.
// Optional build macro DSC_FEEDER_BORDER_EN: border pixels (row 0 / column 0) emit a zero result instead of being skipped.
module dsc_roberts_window_feeder #(
    parameter int DATA_WIDTH = 5,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  core_en,
    output logic [DATA_WIDTH-1:0] core_in00,
    output logic [DATA_WIDTH-1:0] core_in01,
    output logic [DATA_WIDTH-1:0] core_in10,
    output logic [DATA_WIDTH-1:0] core_in11,
    input  logic [DATA_WIDTH-1:0] core_out,
    input  logic                  core_done,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_RUN,
        ST_OUT
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] line_q [IMG_WIDTH];
    logic [COL_W-1:0]      col_q;
    logic [COL_W-1:0]      col_d;
    logic [ROW_W-1:0]      row_q;
    logic [ROW_W-1:0]      row_d;
    logic [DATA_WIDTH-1:0] up_left_q;
    logic [DATA_WIDTH-1:0] cur_left_q;
    logic [DATA_WIDTH-1:0] in00_q;
    logic [DATA_WIDTH-1:0] in01_q;
    logic [DATA_WIDTH-1:0] in10_q;
    logic [DATA_WIDTH-1:0] in11_q;
    logic [DATA_WIDTH-1:0] res_out_q;
    logic                  pix_ready_q;
    logic                  core_en_q;
    logic                  res_valid_q;
    logic                  frame_done_q;
    logic                  last_q;

    logic                  accept;
    logic                  at_last_col;
    logic                  at_last_row;
    logic                  interior;
    logic [DATA_WIDTH-1:0] prev_pix;

    assign accept      = pix_valid && pix_ready_q;
    assign at_last_col = (col_q == LAST_COL);
    assign at_last_row = (row_q == LAST_ROW);
    assign interior    = (row_q != '0) && (col_q != '0);
    assign prev_pix    = line_q[col_q];

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (at_last_col) begin
            col_d = '0;
            row_d = at_last_row ? '0 : row_q + 1'b1;
        end
    end

    // Row buffer is deliberately unreset: row 0 never launches, so stale contents are never consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[col_q] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_ACCEPT;
            col_q        <= '0;
            row_q        <= '0;
            up_left_q    <= '0;
            cur_left_q   <= '0;
            in00_q       <= '0;
            in01_q       <= '0;
            in10_q       <= '0;
            in11_q       <= '0;
            res_out_q    <= '0;
            pix_ready_q  <= 1'b0;
            core_en_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_ACCEPT: begin
                    pix_ready_q <= 1'b1;
                    if (accept) begin
                        up_left_q  <= prev_pix;
                        cur_left_q <= pix_in;
                        col_q      <= col_d;
                        row_q      <= row_d;
                        last_q     <= at_last_col && at_last_row;
                        if (interior) begin
                            in00_q      <= up_left_q;
                            in01_q      <= prev_pix;
                            in10_q      <= cur_left_q;
                            in11_q      <= pix_in;
                            core_en_q   <= 1'b1;
                            pix_ready_q <= 1'b0;
                            state_q     <= ST_RUN;
                        end
`ifdef DSC_FEEDER_BORDER_EN
                        else begin
                            res_out_q   <= '0;
                            res_valid_q <= 1'b1;
                            pix_ready_q <= 1'b0;
                            state_q     <= ST_OUT;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        res_out_q   <= core_out;
                        core_en_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // Holding here keeps core_en low for at least one cycle between operations.
                    if (res_ready) begin
                        res_valid_q  <= 1'b0;
                        pix_ready_q  <= 1'b1;
                        frame_done_q <= last_q;
                        state_q      <= ST_ACCEPT;
                    end
                end
                default: begin
                    state_q <= ST_ACCEPT;
                end
            endcase
        end
    end

    assign pix_ready  = pix_ready_q;
    assign core_en    = core_en_q;
    assign core_in00  = in00_q;
    assign core_in01  = in01_q;
    assign core_in10  = in10_q;
    assign core_in11  = in11_q;
    assign res_out    = res_out_q;
    assign res_valid  = res_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dsc_roberts_window_feeder.sv
// Scoreboard bench for dsc_roberts_window_feeder: a raster/window reference model feeds result and window queues.
// Also builds with DSC_FEEDER_BORDER_EN, where border pixels expect a zero result.
module tb_dsc_roberts_window_feeder;

    localparam int DW = 5;
    localparam int W  = 4;
    localparam int H  = 3;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } res_t;

    typedef struct {
        logic [DW-1:0] w00;
        logic [DW-1:0] w01;
        logic [DW-1:0] w10;
        logic [DW-1:0] w11;
    } win_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          core_en;
    logic [DW-1:0] core_in00, core_in01, core_in10, core_in11;
    logic [DW-1:0] core_out = '0;
    logic          core_done = 1'b0;
    logic [DW-1:0] res_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          frame_done;

    res_t          expQ[$];
    win_t          winQ[$];
    logic [DW-1:0] frameMem [W*H];
    int            pixIdx = 0;
    int            checks = 0;
    int            fails = 0;
    int            latency = 32;
    bit            readyRandom = 0;
    bit            stallArm = 0;
    int            runs = 0;
    int            runCycle = 0;
    int            framesExpected = 0;
    int            framesSeen = 0;

    dsc_roberts_window_feeder #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .core_en   (core_en),
        .core_in00 (core_in00),
        .core_in01 (core_in01),
        .core_in10 (core_in10),
        .core_in11 (core_in11),
        .core_out  (core_out),
        .core_done (core_done),
        .res_out   (res_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void reportTimeout(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: timed out, got no response, expected one", name);
    endfunction

    // Reference model: a frame is a raster array; each window is read straight from it by coordinates.
    function automatic void modelAccept(input logic [DW-1:0] p);
        int   r = pixIdx / W;
        int   c = pixIdx % W;
        bit   last = (r == H - 1) && (c == W - 1);
        win_t win;
        res_t item;
        frameMem[pixIdx] = p;
        if (r >= 1 && c >= 1) begin
            win.w00 = frameMem[pixIdx - W - 1];
            win.w01 = frameMem[pixIdx - W];
            win.w10 = frameMem[pixIdx - 1];
            win.w11 = p;
            winQ.push_back(win);
            item.data = win.w00 ^ win.w11;
            item.last = last;
            expQ.push_back(item);
        end else begin
`ifdef DSC_FEEDER_BORDER_EN
            item.data = '0;
            item.last = last;
            expQ.push_back(item);
`endif
        end
        if (last) framesExpected++;
        pixIdx = (pixIdx + 1) % (W * H);
    endfunction

    // Called at a negedge; offers one pixel and returns one negedge after it is accepted.
    task automatic applyStimulus(input logic [DW-1:0] p, input int gapMax);
        int gap = (gapMax > 0) ? $urandom_range(gapMax, 0) : 0;
        bit accepted = 0;
        repeat (gap) @(negedge clk);
        pix_in = p;
        pix_valid = 1'b1;
        for (int k = 0; k < 500 && !accepted; k++) begin
            if (pix_ready === 1'b1) begin
                modelAccept(p);
                accepted = 1;
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_in = DW'($urandom);
        if (!accepted) reportTimeout("pixel accept");
    endtask

    task automatic waitIdle();
        bit idle = 0;
        for (int k = 0; k < 3000 && !idle; k++) begin
            @(negedge clk);
            idle = (expQ.size() == 0) && (res_valid === 1'b0) && (pix_ready === 1'b1);
        end
        if (!idle) reportTimeout("drain");
        repeat (3) @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " core_en"}, 32'(core_en), 0);
        checkOutput({tag, " res_valid"}, 32'(res_valid), 0);
        checkOutput({tag, " frame_done"}, 32'(frame_done), 0);
        checkOutput({tag, " res_out"}, 32'(res_out), 0);
        checkOutput({tag, " core_in"}, 32'({core_in00, core_in01, core_in10, core_in11}), 0);
    endtask

    // Core model: done after 'latency' extra cycles, result in00 ^ in11; spurious done pulses while idle.
    initial begin
        bit   prevEn = 0;
        win_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                runCycle = 0;
                prevEn = 0;
                core_done = 1'b0;
            end else if (core_en === 1'b1) begin
                runCycle++;
                if (runCycle == 1) begin
                    runs++;
                    if (winQ.size() == 0) begin
                        reportTimeout("launch without expected window");
                    end else begin
                        w = winQ.pop_front();
                        checkOutput("window in00", 32'(core_in00), 32'(w.w00));
                        checkOutput("window in01", 32'(core_in01), 32'(w.w01));
                        checkOutput("window in10", 32'(core_in10), 32'(w.w10));
                        checkOutput("window in11", 32'(core_in11), 32'(w.w11));
                    end
                end
                core_done = (runCycle == latency + 1);
                core_out = core_done ? (core_in00 ^ core_in11) : DW'($urandom);
                prevEn = 1;
            end else begin
                if (prevEn) checkOutput("core_en run length", 32'(runCycle), 32'(latency + 1));
                prevEn = 0;
                runCycle = 0;
                core_done = ($urandom_range(3, 0) == 0);
                core_out = DW'($urandom);
            end
        end
    end

    // Monitor: drives res_ready, pops and compares each handshake, tracks frame_done.
    initial begin
        bit   fdExpect = 0;
        int   stallLeft = 0;
        bit   rdy;
        res_t item;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fdExpect = 0;
                stallLeft = 0;
                res_ready = 1'b0;
            end else begin
                checkOutput("frame_done", 32'(frame_done), 32'(fdExpect));
                if (frame_done === 1'b1) framesSeen++;
                fdExpect = 0;
                rdy = readyRandom ? 1'($urandom_range(1, 0)) : 1'b1;
                if (res_valid === 1'b1) begin
                    checkOutput("core_en low in OUT", 32'(core_en), 0);
                    checkOutput("pix_ready low in OUT", 32'(pix_ready), 0);
                    if (stallArm) begin
                        stallArm = 0;
                        stallLeft = 10;
                    end
                    if (stallLeft > 0) begin
                        stallLeft--;
                        rdy = 1'b0;
                        if (expQ.size() != 0) checkOutput("res_out held", 32'(res_out), 32'(expQ[0].data));
                    end
                    if (rdy) begin
                        if (expQ.size() == 0) begin
                            reportTimeout("unexpected result");
                        end else begin
                            item = expQ.pop_front();
                            checkOutput("res_out", 32'(res_out), 32'(item.data));
                            fdExpect = item.last;
                        end
                    end
                end
                res_ready = rdy;
            end
        end
    end

    initial begin
        bit done;
        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("pix_ready in reset", 32'(pix_ready), 0);
        checkResetState("reset");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("pix_ready after release", 32'(pix_ready), 1);
        checkResetState("post-reset");

        $display("[TB] frame A: pixels 0..11, latency 32");
        latency = 32;
        for (int i = 0; i < W * H; i++) applyStimulus(DW'(i), 0);
        waitIdle();

        $display("[TB] frame B: first result stalled 10 cycles");
        stallArm = 1;
        for (int i = 0; i < W * H; i++) applyStimulus(DW'(i), 0);
        waitIdle();

        $display("[TB] frame C: latency 0, random pixels and res_ready");
        latency = 0;
        readyRandom = 1;
        for (int i = 0; i < W * H; i++) applyStimulus(DW'($urandom), 3);
        waitIdle();

        $display("[TB] reset during second run");
        latency = 32;
        readyRandom = 0;
        runs = 0;
        for (int i = 0; i < W + 3; i++) applyStimulus(DW'(i), 0);
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = (runs == 2) && (runCycle >= 10);
        end
        if (!done) reportTimeout("second run");
        rst = 1'b0;
        #1;
        checkOutput("core_en async drop", 32'(core_en), 0);
        checkOutput("pix_ready in mid-run reset", 32'(pix_ready), 0);
        expQ.delete();
        winQ.delete();
        pixIdx = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("pix_ready after mid-run reset", 32'(pix_ready), 1);
        checkResetState("mid-run reset");

        $display("[TB] frame D: pixels 20..31");
        for (int i = 20; i < 20 + W * H; i++) applyStimulus(DW'(i), 0);
        waitIdle();

        $display("[TB] frames E: random latency and traffic");
        readyRandom = 1;
        for (int f = 0; f < 2; f++) begin
            latency = $urandom_range(5, 0);
            for (int i = 0; i < W * H; i++) applyStimulus(DW'($urandom), 2);
            waitIdle();
        end

        checkOutput("scoreboard drained", 32'(expQ.size()), 0);
        checkOutput("window queue drained", 32'(winQ.size()), 0);
        checkOutput("frame_done count", 32'(framesSeen), 32'(framesExpected));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
